// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined Hack ALU: S1 preprocesses operands, S2 holds the result.
// Optional op_count output is enabled by defining ALU_PIPE_STATS_EN.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef ALU_PIPE_STATS_EN
  ,
  output logic [WIDTH-1:0] op_count
`endif
);

  localparam int unsigned CTRL_ZX = 5;
  localparam int unsigned CTRL_NX = 4;
  localparam int unsigned CTRL_ZY = 3;
  localparam int unsigned CTRL_NY = 2;
  localparam int unsigned CTRL_F  = 1;
  localparam int unsigned CTRL_NO = 0;

  typedef struct packed {
    logic [WIDTH-1:0] xp;
    logic [WIDTH-1:0] yp;
    logic             f;
    logic             no;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             zr;
    logic             ng;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d, s1_in;
  s2_t  s2_q, s2_d, s2_in;
  logic out_hs_c;
  logic s2_load_c;
  logic in_hs_c;
  logic [WIDTH-1:0] sum_c;

  // Operand preprocessing from the raw inputs (zero then optional invert).
  always_comb begin
    s1_in    = '0;
    s1_in.xp = ctrl[CTRL_ZX] ? '0 : x;
    if (ctrl[CTRL_NX]) begin
      s1_in.xp = ~s1_in.xp;
    end
    s1_in.yp = ctrl[CTRL_ZY] ? '0 : y;
    if (ctrl[CTRL_NY]) begin
      s1_in.yp = ~s1_in.yp;
    end
    s1_in.f  = ctrl[CTRL_F];
    s1_in.no = ctrl[CTRL_NO];
  end

  // Result function on the S1 contents; addition wraps silently.
  always_comb begin
    s2_in = '0;
    sum_c = WIDTH'(s1_q.xp + s1_q.yp);
    s2_in.r = s1_q.f ? sum_c : (s1_q.xp & s1_q.yp);
    if (s1_q.no) begin
      s2_in.r = ~s2_in.r;
    end
    s2_in.zr = (s2_in.r == '0);
    s2_in.ng = s2_in.r[WIDTH-1];
  end

  // Handshakes: in_ready depends only on out_ready and stage valids.
  always_comb begin
    out_hs_c  = s2_valid_q && out_ready;
    s2_load_c = !s2_valid_q || out_hs_c;
    in_ready  = !s1_valid_q || s2_load_c;
    in_hs_c   = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_hs_c) begin
      s1_d = s1_in;
    end
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = s2_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = s2_q.r;
  assign zr        = s2_q.zr;
  assign ng        = s2_q.ng;

`ifdef ALU_PIPE_STATS_EN
  logic [WIDTH-1:0] op_count_q, op_count_d;

  // Completed-operation counter, wraps naturally at full scale.
  always_comb begin
    op_count_d = op_count_q;
    if (out_hs_c) begin
      op_count_d = WIDTH'(op_count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed Hack functions, backpressure, streaming, reset.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
`ifdef ALU_PIPE_STATS_EN
  logic [15:0] op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [17:0] exp_q[$];

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
`ifdef ALU_PIPE_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference Hack ALU: returns {zr, ng, out}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [5:0] c);
    logic [15:0] xa;
    logic [15:0] yb;
    logic [15:0] r;
    xa = a;
    yb = b;
    if (c[5]) xa = 16'h0000;
    if (c[4]) xa = ~xa;
    if (c[3]) yb = 16'h0000;
    if (c[2]) yb = ~yb;
    if (c[1]) r = xa + yb;
    else      r = xa & yb;
    if (c[0]) r = ~r;
    return {(r == 16'h0000), r[15], r};
  endfunction

  // Handshakes are evaluated at the falling edge for the coming rising edge.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          check("sb_out", 32'(out), 32'(e[15:0]));
          check("sb_zr", 32'(zr), 32'(e[17]));
          check("sb_ng", 32'(ng), 32'(e[16]));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(model(x, y, ctrl));
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
    logic acc;
    acc      = 1'b0;
    x        = a;
    y        = b;
    ctrl     = c;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Single op under backpressure; result must be present two edges after acceptance.
  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                        input logic [15:0] eo, input logic ez, input logic en);
    out_ready = 1'b0;
    do_op(a, b, c);
    @(posedge clk);
    @(negedge clk);
    check("dir_valid", 32'(out_valid), 32'd1);
    check("dir_out", 32'(out), 32'(eo));
    check("dir_zr", 32'(zr), 32'(ez));
    check("dir_ng", 32'(ng), 32'(en));
    @(posedge clk);
    #1;
    drain();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] bx[4];
    logic [15:0] by[4];
    logic [5:0]  bc[4];
    logic [17:0] e0;
    int base;
    int sent;
    logic hs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    ctrl      = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_zr", 32'(zr), 32'd0);
    check("rst_ng", 32'(ng), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_PIPE_STATS_EN
    check("rst_op_count", 32'(op_count), 32'd0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    single(16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0);
    single(16'h0005, 16'h0003, 6'b010011, 16'h0002, 1'b0, 1'b0);
    single(16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
    single(16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);
    single(16'hFFFF, 16'h0002, 6'b000010, 16'h0001, 1'b0, 1'b0);
    single(16'h0F0F, 16'h00FF, 6'b000000, 16'h000F, 1'b0, 1'b0);

    // Backpressure: two accepted, then stall with first result held.
    for (int i = 0; i < 4; i++) begin
      bx[i] = 16'($urandom);
      by[i] = 16'($urandom);
      bc[i] = 6'($urandom);
    end
    e0 = model(bx[0], by[0], bc[0]);
    base = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = bx[0]; y = by[0]; ctrl = bc[0];
    @(negedge clk);
    check("bp_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    x = bx[1]; y = by[1]; ctrl = bc[1];
    @(negedge clk);
    check("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    x = bx[2]; y = by[2]; ctrl = bc[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_rdy", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_out", 32'(out), 32'(e0[15:0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    x = bx[3]; y = by[3]; ctrl = bc[3];
    @(negedge clk);
    check("bp_rdy3", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("bp_count", 32'(n_out - base), 32'd4);

    // Streaming with random backpressure.
    base = n_out;
    sent = 0;
    in_valid = 1'b1;
    x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
      @(negedge clk);
      if (out_ready) check("stream_thru", 32'(in_ready), 32'd1);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        if (sent < 100) begin
          x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'd100);
    drain();
    check("stream_count", 32'(n_out - base), 32'd100);

    // Reset with both stages occupied, then a fresh op right after release.
    out_ready = 1'b0;
    do_op(16'h0001, 16'h0001, 6'b000010);
    do_op(16'h0002, 16'h0002, 6'b000010);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    check("mid_rst_zr", 32'(zr), 32'd0);
    x = 16'h0007; y = 16'h0009; ctrl = 6'b000111;
    in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    base = n_out;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_out", 32'(out), 32'h0002);
    drain();
    check("post_rst_count", 32'(n_out - base), 32'd1);

`ifdef ALU_PIPE_STATS_EN
    out_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("stats_rst", 32'(op_count), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    sent = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 70000 && sent < 65537; cyc++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
        if (sent >= 65537) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("stats_wrap", 32'(op_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
